// File: rtl/demux1t2_32_buf_if.sv
// Bundle for demux1t2_32_buf: one input stream (i, s, i_valid/i_ready) and two output
// streams (oN, oN_valid/oN_ready) plus the occupancy counts of the two FIFOs.
interface demux1t2_32_buf_if #(
    parameter int unsigned CW = 2
);
    logic [31:0]   i;
    logic          s;
    logic          i_valid;
    logic          i_ready;
    logic [31:0]   o1;
    logic          o1_valid;
    logic          o1_ready;
    logic [31:0]   o2;
    logic          o2_valid;
    logic          o2_ready;
    logic [CW-1:0] o1_count;
    logic [CW-1:0] o2_count;

    // Demux side: consumes the input stream and produces both output streams
    modport slave (
        input  i, s, i_valid, o1_ready, o2_ready,
        output i_ready, o1, o1_valid, o2, o2_valid, o1_count, o2_count
    );

    // Environment side: the producer and both consumers
    modport master (
        output i, s, i_valid, o1_ready, o2_ready,
        input  i_ready, o1, o1_valid, o2, o2_valid, o1_count, o2_count
    );
endinterface

// File: rtl/demux1t2_32_buf.sv
// 1:2 valid/ready demux for 32-bit beats. s=0 steers a beat to o1 and s=1 steers it to o2.
// Each output has its own DEPTH-entry FIFO, so a stalled consumer never blocks the other one.
module demux1t2_32_buf #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = 2
) (
    input logic               clk,
    input logic               rst_n,
    demux1t2_32_buf_if.slave  bus
);
    localparam int unsigned DW = 32;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned NF = 2;

    logic [DW-1:0] mem_q    [NF][DEPTH];
    logic [PW-1:0] wr_ptr_q [NF];
    logic [PW-1:0] wr_ptr_d [NF];
    logic [PW-1:0] rd_ptr_q [NF];
    logic [PW-1:0] rd_ptr_d [NF];
    logic [CW-1:0] cnt_q    [NF];
    logic [CW-1:0] cnt_d    [NF];
    logic          valid_q  [NF];
    logic          valid_d  [NF];

    logic          full_c   [NF];
    logic          push_c   [NF];
    logic          pop_c    [NF];
    logic          oready_c [NF];
    logic          i_ready_c;

    assign oready_c[0] = bus.o1_ready;
    assign oready_c[1] = bus.o2_ready;

    // The full check uses the registered count only, so a FIFO being popped still refuses a push
    always_comb begin
        for (int k = 0; k < NF; k++) begin
            full_c[k] = (cnt_q[k] == CW'(DEPTH));
        end
        i_ready_c = bus.s ? !full_c[1] : !full_c[0];
    end

    // Per-FIFO next state: pointers, occupancy and the registered valid
    always_comb begin
        for (int k = 0; k < NF; k++) begin
            push_c[k]   = 1'b0;
            pop_c[k]    = 1'b0;
            wr_ptr_d[k] = wr_ptr_q[k];
            rd_ptr_d[k] = rd_ptr_q[k];
            cnt_d[k]    = cnt_q[k];
            valid_d[k]  = valid_q[k];
        end
        push_c[0] = bus.i_valid && i_ready_c && !bus.s;
        push_c[1] = bus.i_valid && i_ready_c &&  bus.s;
        for (int k = 0; k < NF; k++) begin
            pop_c[k] = valid_q[k] && oready_c[k];
            if (push_c[k]) begin
                wr_ptr_d[k] = wr_ptr_q[k] + PW'(1);
            end
            if (pop_c[k]) begin
                rd_ptr_d[k] = rd_ptr_q[k] + PW'(1);
            end
            unique case ({push_c[k], pop_c[k]})
                2'b10:   cnt_d[k] = cnt_q[k] + CW'(1);
                2'b01:   cnt_d[k] = cnt_q[k] - CW'(1);
                default: cnt_d[k] = cnt_q[k];
            endcase
            valid_d[k] = (cnt_d[k] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NF; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
                valid_q[k]  <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NF; k++) begin
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
                cnt_q[k]    <= cnt_d[k];
                valid_q[k]  <= valid_d[k];
            end
        end
    end

    // Storage has no reset; contents are only observable behind a set valid
    always_ff @(posedge clk) begin
        for (int k = 0; k < NF; k++) begin
            if (push_c[k]) begin
                mem_q[k][wr_ptr_q[k]] <= bus.i;
            end
        end
    end

    assign bus.i_ready  = i_ready_c;
    assign bus.o1       = mem_q[0][rd_ptr_q[0]];
    assign bus.o2       = mem_q[1][rd_ptr_q[1]];
    assign bus.o1_valid = valid_q[0];
    assign bus.o2_valid = valid_q[1];
    assign bus.o1_count = cnt_q[0];
    assign bus.o2_count = cnt_q[1];

endmodule

// File: tb/tb_demux1t2_32_buf.sv
// Bench for demux1t2_32_buf: directed vectors feed per-output scoreboard queues, and a
// negedge monitor pops and compares every beat the DUT hands to a consumer.
module tb_demux1t2_32_buf;
    localparam int unsigned CW = 2;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    logic [31:0] exp1_q[$];
    logic [31:0] exp2_q[$];

    demux1t2_32_buf_if #(.CW(CW)) bus ();

    demux1t2_32_buf #(.DEPTH(2), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer one beat until accepted; queue its expected output on the accepting cycle
    task automatic send(input logic [31:0] data, input logic sel, output int stalls);
        bool_loop: begin
            stalls      = 0;
            bus.i       = data;
            bus.s       = sel;
            bus.i_valid = 1'b1;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if (bus.i_ready) begin
                    if (sel) exp2_q.push_back(data);
                    else     exp1_q.push_back(data);
                    @(posedge clk);
                    #1;
                    bus.i_valid = 1'b0;
                    disable bool_loop;
                end
                stalls++;
                @(posedge clk);
                #1;
            end
            bus.i_valid = 1'b0;
            chk("send_timeout", 32'(stalls), 32'd0);
        end
    endtask

    // Scoreboard monitor: each handshake seen on an output must match the queue head
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.o1_valid && bus.o1_ready) begin
                if (exp1_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL o1_unexpected: got %h expected none", bus.o1);
                end else chk("o1_data", bus.o1, exp1_q.pop_front());
            end
            if (rst_n && bus.o2_valid && bus.o2_ready) begin
                if (exp2_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL o2_unexpected: got %h expected none", bus.o2);
                end else chk("o2_data", bus.o2, exp2_q.pop_front());
            end
        end
    end

    // Producer rule: i and s stay put while a beat is offered but not taken
    initial begin
        logic        hold;
        logic [31:0] prev_i;
        logic        prev_s;
        hold = 1'b0;
        prev_i = '0;
        prev_s = 1'b0;
        forever begin
            @(negedge clk);
            if (hold && bus.i_valid && (bus.i !== prev_i || bus.s !== prev_s)) begin
                n_checks++; n_fail++;
                $display("FAIL protocol: got %h/%b expected %h/%b", bus.i, bus.s, prev_i, prev_s);
            end
            hold   = bus.i_valid && !bus.i_ready;
            prev_i = bus.i;
            prev_s = bus.s;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        int total;
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.i        = '0;
        bus.s        = 1'b0;
        bus.i_valid  = 1'b0;
        bus.o1_ready = 1'b1;
        bus.o2_ready = 1'b1;

        // Reset then idle
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_o1_valid", 32'(bus.o1_valid), 32'd0);
        chk("rst_o2_valid", 32'(bus.o2_valid), 32'd0);
        chk("rst_o1_count", 32'(bus.o1_count), 32'd0);
        chk("rst_o2_count", 32'(bus.o2_count), 32'd0);
        bus.s = 1'b0; #1;
        chk("rst_i_ready_s0", 32'(bus.i_ready), 32'd1);
        bus.s = 1'b1; #1;
        chk("rst_i_ready_s1", 32'(bus.i_ready), 32'd1);
        @(posedge clk); #1;

        // Steering
        send(32'hAAAA0001, 1'b0, stalls);
        chk("steer_o1_valid", 32'(bus.o1_valid), 32'd1);
        chk("steer_o1_data", bus.o1, 32'hAAAA0001);
        send(32'hBBBB0002, 1'b1, stalls);
        chk("steer_o2_valid", 32'(bus.o2_valid), 32'd1);
        chk("steer_o2_data", bus.o2, 32'hBBBB0002);
        repeat (3) @(posedge clk);
        #1;
        chk("steer_o1_drained", 32'(bus.o1_valid), 32'd0);
        chk("steer_o2_drained", 32'(bus.o2_valid), 32'd0);

        // Backpressure and full
        bus.o1_ready = 1'b0;
        send(32'd1, 1'b0, stalls);
        send(32'd2, 1'b0, stalls);
        chk("full_o1_count", 32'(bus.o1_count), 32'd2);
        bus.s = 1'b0; #1;
        chk("full_i_ready_s0", 32'(bus.i_ready), 32'd0);
        bus.s = 1'b1; #1;
        chk("full_i_ready_s1", 32'(bus.i_ready), 32'd1);
        bus.i = 32'd3; bus.s = 1'b0; bus.i_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("full_refuse_count", 32'(bus.o1_count), 32'd2);
        chk("full_hold_data", bus.o1, 32'd1);
        chk("full_hold_valid", 32'(bus.o1_valid), 32'd1);
        bus.i_valid = 1'b0;
        @(posedge clk); #1;
        send(32'h55, 1'b1, stalls);
        chk("bypass_o2_valid", 32'(bus.o2_valid), 32'd1);
        chk("bypass_o2_data", bus.o2, 32'h55);
        chk("bypass_o1_count", 32'(bus.o1_count), 32'd2);

        // Full with pop: the push waits one cycle
        bus.o1_ready = 1'b1;
        bus.i = 32'd4; bus.s = 1'b0; bus.i_valid = 1'b1;
        #1;
        chk("fullpop_i_ready", 32'(bus.i_ready), 32'd0);
        @(posedge clk); #1;
        chk("fullpop_count", 32'(bus.o1_count), 32'd1);
        send(32'd4, 1'b0, stalls);
        chk("fullpop_next_accept", 32'(stalls), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("fullpop_o1_empty", 32'(bus.o1_count), 32'd0);
        chk("fullpop_o2_empty", 32'(bus.o2_count), 32'd0);

        // Streaming with alternating routes across pointer wrap
        total = 0;
        for (int n = 0; n < 20; n++) begin
            send(32'h100 + 32'(n), n[0], stalls);
            total += stalls;
        end
        chk("stream_bubbles", 32'(total), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("stream_q1_empty", 32'(exp1_q.size()), 32'd0);
        chk("stream_q2_empty", 32'(exp2_q.size()), 32'd0);

        // Reset mid-operation
        bus.o1_ready = 1'b0;
        bus.o2_ready = 1'b0;
        send(32'hA1, 1'b0, stalls);
        send(32'hA2, 1'b0, stalls);
        send(32'hB1, 1'b1, stalls);
        chk("midrst_pre_o1_count", 32'(bus.o1_count), 32'd2);
        chk("midrst_pre_o2_count", 32'(bus.o2_count), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_o1_valid", 32'(bus.o1_valid), 32'd0);
        chk("midrst_o2_valid", 32'(bus.o2_valid), 32'd0);
        chk("midrst_o1_count", 32'(bus.o1_count), 32'd0);
        chk("midrst_o2_count", 32'(bus.o2_count), 32'd0);
        exp1_q.delete();
        exp2_q.delete();
        #1 rst_n = 1'b1;
        bus.o1_ready = 1'b1;
        bus.o2_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_idle_o1", 32'(bus.o1_valid), 32'd0);
        chk("midrst_idle_o2", 32'(bus.o2_valid), 32'd0);
        send(32'h00C0FFEE, 1'b0, stalls);
        chk("midrst_new_data", bus.o1, 32'h00C0FFEE);
        repeat (3) @(posedge clk);
        #1;
        chk("end_q1_empty", 32'(exp1_q.size()), 32'd0);
        chk("end_q2_empty", 32'(exp2_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
